// File: rtl/dsp_pkg.sv
// Shared constants and types for the DSP48A1 MAC sequencer.
// Latencies match A1REG=1, B1REG=1, MREG=1, PREG=1 with direct B input.
package dsp_pkg;

    localparam logic [7:0] OPM_HOLD  = 8'h08;
    localparam logic [7:0] OPM_START = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    localparam int OPM_DLY  = 2;
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic v;
        logic first;
        logic last;
    } tag_t;

    localparam tag_t TAG_NONE = '{v: 1'b0, first: 1'b0, last: 1'b0};

endpackage

// File: rtl/dsp_tag_delay.sv
// Fixed-depth shift register of issue tags that tracks products through the slice.
module dsp_tag_delay
    import dsp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  tag_t tag_i,
    output tag_t tag_o,
    output logic any_v_o,
    output logic any_last_o
);

    tag_t stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= TAG_NONE;
            end
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

    always_comb begin
        any_v_o    = 1'b0;
        any_last_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_v_o    = any_v_o | stage_q[i].v;
            any_last_o = any_last_o | stage_q[i].last;
        end
    end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Frames a sample stream into NTAPS-long dot products on one DSP48A1 slice,
// drives A/B/OPMODE and collects P into a valid/ready holding register.
module dsp_mac_sequencer #(
    parameter int NTAPS    = 8,
    parameter int DATA_W   = 18,
    parameter int ACC_W    = 48,
    parameter int OPM_DLY  = dsp_pkg::OPM_DLY,
    parameter int PIPE_LAT = dsp_pkg::PIPE_LAT
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      coef_we,
    input  logic [$clog2(NTAPS)-1:0]  coef_addr,
    input  logic [DATA_W-1:0]         coef_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    output logic [DATA_W-1:0]         dsp_a,
    output logic [DATA_W-1:0]         dsp_b,
    output logic [7:0]                dsp_opmode,
    input  logic [ACC_W-1:0]          dsp_p,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ACC_W-1:0]          m_data,
    output logic                      busy
);

    import dsp_pkg::*;

    localparam int IDX_W = $clog2(NTAPS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

    logic [IDX_W-1:0]  tap_idx_q, tap_idx_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] coef_q [NTAPS];
    tag_t              tag_q, tag_d, opm_tag, comp_tag;
    logic              m_valid_q, m_valid_d;
    logic [ACC_W-1:0]  m_data_q, m_data_d;
    logic              opm_any_v, opm_any_last, comp_any_v, comp_any_last;
    logic              accept, last_tap, comp_in_flight, land;
    logic              unused_tag_bits;

    assign last_tap       = (tap_idx_q == LAST_IDX);
    assign comp_in_flight = tag_q.last | opm_any_last | comp_any_last;
    // Only the last tap stalls, so a landing result never finds the register occupied.
    assign s_ready = !RST && !(last_tap && (comp_in_flight || (m_valid_q && !m_ready)));
    assign accept  = s_valid && s_ready;
    assign land    = comp_tag.v && comp_tag.last;

    always_comb begin
        tap_idx_d = tap_idx_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = TAG_NONE;
        if (accept) begin
            a_d         = s_data;
            b_d         = coef_q[tap_idx_q];
            tag_d.v     = 1'b1;
            tag_d.first = (tap_idx_q == '0);
            tag_d.last  = last_tap;
            tap_idx_d   = last_tap ? '0 : tap_idx_q + 1'b1;
        end
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (land) begin
            m_valid_d = 1'b1;
            m_data_d  = dsp_p;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tap_idx_q <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= TAG_NONE;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            tap_idx_q <= tap_idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Bank survives reset; an issue in the write cycle still reads the old value.
    always_ff @(posedge CLK) begin
        if (coef_we && coef_addr <= LAST_IDX) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    dsp_tag_delay #(.DEPTH(OPM_DLY)) u_opm_dly (
        .clk_i      (CLK),
        .rst_i      (RST),
        .tag_i      (tag_q),
        .tag_o      (opm_tag),
        .any_v_o    (opm_any_v),
        .any_last_o (opm_any_last)
    );

    dsp_tag_delay #(.DEPTH(PIPE_LAT)) u_comp_dly (
        .clk_i      (CLK),
        .rst_i      (RST),
        .tag_i      (tag_q),
        .tag_o      (comp_tag),
        .any_v_o    (comp_any_v),
        .any_last_o (comp_any_last)
    );

    always_comb begin
        if (!opm_tag.v) begin
            dsp_opmode = OPM_HOLD;
        end else if (opm_tag.first) begin
            dsp_opmode = OPM_START;
        end else begin
            dsp_opmode = OPM_ACC;
        end
    end

    assign unused_tag_bits = opm_tag.last ^ comp_tag.first;

    assign dsp_a   = a_q;
    assign dsp_b   = b_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign busy    = (tap_idx_q != '0) | tag_q.v | opm_any_v | comp_any_v;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A1/B1, M and P registers) closing the loop on dsp_p.
module tb_dsp_mac_sequencer;

    localparam int NT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [17:0] coef_data;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_data;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic [47:0] dsp_p;
    logic        m_valid;
    logic        m_ready;
    logic [47:0] m_data;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] opm_log [0:4095];

    dsp_mac_sequencer #(.NTAPS(NT), .DATA_W(18), .ACC_W(48)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .dsp_a      (dsp_a),
        .dsp_b      (dsp_b),
        .dsp_opmode (dsp_opmode),
        .dsp_p      (dsp_p),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Slice model: A1/B1 -> M -> P, RSTP tied to RST.
    logic [17:0] a1_q, b1_q;
    logic [35:0] m_q;
    logic [47:0] p_q;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            a1_q <= '0;
            b1_q <= '0;
            m_q  <= '0;
            p_q  <= '0;
        end else begin
            a1_q <= dsp_a;
            b1_q <= dsp_b;
            m_q  <= a1_q * b1_q;
            case (dsp_opmode)
                8'h01:   p_q <= 48'(m_q);
                8'h09:   p_q <= p_q + 48'(m_q);
                default: p_q <= p_q;
            endcase
        end
    end
    assign dsp_p = p_q;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (cyc < 4096) opm_log[cyc] = dsp_opmode;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wcoef(input logic [1:0] a, input logic [17:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic send(input logic [17:0] d, output int e);
        int k;
        s_valid = 1'b1;
        s_data  = d;
        k = 0;
        while (!s_ready && k < 50) begin
            tick();
            k++;
        end
        if (!s_ready) chk("send_timeout", 64'd0, 64'd1);
        tick();
        e = cyc;
    endtask

    task automatic wait_mv(output int e);
        int k;
        k = 0;
        while (!m_valid && k < 40) begin
            tick();
            k++;
        end
        if (!m_valid) chk("mvalid_timeout", 64'd0, 64'd1);
        e = cyc;
    endtask

    initial begin
        int e0, e1, e3, eb, er;
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e3, ea, eb, er;
        RST = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        s_valid = 1'b1; s_data = 18'd77; m_ready = 1'b1;
        #3;
        chk("rst_dsp_a",   dsp_a, 0);
        chk("rst_dsp_b",   dsp_b, 0);
        chk("rst_opmode",  dsp_opmode, 8'h08);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data",  m_data, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_s_ready", s_ready, 0);
        s_valid = 1'b0;
        tick(); tick();
        RST = 1'b0;
        tick();
        wcoef(2'd0, 18'd1); wcoef(2'd1, 18'd2); wcoef(2'd2, 18'd3); wcoef(2'd3, 18'd4);

        // single frame, no stalls
        send(18'd10, e0);
        chk("t1_dsp_a", dsp_a, 10);
        chk("t1_dsp_b", dsp_b, 1);
        chk("t1_busy",  busy, 1);
        send(18'd20, e1); send(18'd30, e1); send(18'd40, e3);
        s_valid = 1'b0;
        wait_mv(er);
        chk("t1_latency", er - e3, 4);
        chk("t1_m_data",  m_data, 300);
        tick();
        chk("t1_pulse", m_valid, 0);
        chk("t1_opm0", opm_log[e0+2], 8'h01);
        chk("t1_opm1", opm_log[e0+3], 8'h09);
        chk("t1_opm2", opm_log[e0+4], 8'h09);
        chk("t1_opm3", opm_log[e0+5], 8'h09);
        chk("t1_opm_hold", opm_log[e0+6], 8'h08);
        chk("t1_idle", busy, 0);

        // input bubbles
        send(18'd10, e0); send(18'd20, e1);
        s_valid = 1'b0;
        tick(); tick();
        chk("t2_hold_a", dsp_a, 20);
        chk("t2_hold_b", dsp_b, 2);
        send(18'd30, e0); send(18'd40, e3);
        s_valid = 1'b0;
        wait_mv(er);
        chk("t2_m_data", m_data, 300);
        chk("t2_latency", er - e3, 4);
        chk("t2_opm_bub0", opm_log[e1+3], 8'h08);
        chk("t2_opm_bub1", opm_log[e1+4], 8'h08);
        chk("t2_opm_acc",  opm_log[e1+5], 8'h09);
        tick();

        // output backpressure across two frames
        m_ready = 1'b0;
        send(18'd1, e0); send(18'd1, e0); send(18'd1, e0); send(18'd1, ea);
        send(18'd2, e0); send(18'd2, e0); send(18'd2, e0);
        s_data = 18'd2;
        chk("t3_stall_inflight", s_ready, 0);
        tick();
        chk("t3_a_valid", m_valid, 1);
        chk("t3_a_data",  m_data, 10);
        chk("t3_stall_full", s_ready, 0);
        tick(); tick();
        chk("t3_a_held", m_data, 10);
        chk("t3_a_valid_held", m_valid, 1);
        chk("t3_still_stalled", s_ready, 0);
        m_ready = 1'b1;
        #1;
        chk("t3_ready_on_drain", s_ready, 1);
        tick();
        eb = cyc;
        s_valid = 1'b0;
        chk("t3_drained", m_valid, 0);
        // m_ready stays high through the landing cycle
        wait_mv(er);
        chk("t4_valid_on_land", m_valid, 1);
        chk("t4_b_data", m_data, 20);
        chk("t4_latency", er - eb, 4);
        tick();
        chk("t4_b_drained", m_valid, 0);

        // mid-frame reset
        send(18'd10, e0); send(18'd20, e0);
        s_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("t5_dsp_a",   dsp_a, 0);
        chk("t5_dsp_b",   dsp_b, 0);
        chk("t5_opmode",  dsp_opmode, 8'h08);
        chk("t5_busy",    busy, 0);
        chk("t5_s_ready", s_ready, 0);
        chk("t5_m_valid", m_valid, 0);
        tick(); tick();
        RST = 1'b0;
        tick();
        send(18'd10, e0); send(18'd20, e0); send(18'd30, e0); send(18'd40, e3);
        s_valid = 1'b0;
        wait_mv(er);
        chk("t5_m_data", m_data, 300);
        tick();

        // coefficient update between frames
        wcoef(2'd0, 18'd5);
        send(18'd1, e0); send(18'd1, e0); send(18'd1, e0); send(18'd1, e3);
        s_valid = 1'b0;
        wait_mv(er);
        chk("t6_coef_upd", m_data, 14);
        tick();

        // write and issue to tap 0 in the same cycle: old coefficient used
        coef_we = 1'b1; coef_addr = 2'd0; coef_data = 18'd7;
        s_valid = 1'b1; s_data = 18'd1;
        chk("t6_tap0_ready", s_ready, 1);
        tick();
        coef_we = 1'b0;
        send(18'd1, e0); send(18'd1, e0); send(18'd1, e3);
        s_valid = 1'b0;
        wait_mv(er);
        chk("t6_same_cycle_old", m_data, 14);
        tick();
        send(18'd1, e0); send(18'd1, e0); send(18'd1, e0); send(18'd1, e3);
        s_valid = 1'b0;
        wait_mv(er);
        chk("t6_new_coef", m_data, 16);
        tick();

        // full-scale operands
        wcoef(2'd0, 18'h3FFFF); wcoef(2'd1, 18'h3FFFF);
        wcoef(2'd2, 18'h3FFFF); wcoef(2'd3, 18'h3FFFF);
        send(18'h3FFFF, e0); send(18'h3FFFF, e0); send(18'h3FFFF, e0); send(18'h3FFFF, e3);
        s_valid = 1'b0;
        wait_mv(er);
        chk("t7_full_scale", m_data, 48'h3F_FFE0_0004);
        tick();
        chk("t7_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
